// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-prediction tracking slice.
package bp_pkg;

  localparam int unsigned PC_WIDTH = 32;

  // Two-bit saturating BHT counter encodings.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  // Prediction metadata carried alongside an instruction from IF to EX.
  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] pc;
    bht_state_e          pred_state;
    logic                pred_taken;
    logic [PC_WIDTH-1:0] pred_target;
  } bp_meta_t;

  // A counter in either taken state predicts taken.
  function automatic logic state_says_taken(input bht_state_e s);
    return (s == WT) || (s == ST);
  endfunction

endpackage

// File: rtl/bp_meta_reg.sv
// One pipeline stage of prediction metadata; kill beats stall.
module bp_meta_reg
  import bp_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     stall,
  input  logic     kill,
  input  bp_meta_t d,
  output bp_meta_t q
);

  // Stage register: clear on reset or kill, hold on stall, else advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (kill) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bp_track_unit.sv
// Tracks branch predictions from IF to EX, detects mispredicts, drives the
// BHT update and redirect, and keeps branch/mispredict statistics.
module bp_track_unit
  import bp_pkg::*;
#(
  parameter int unsigned s_index   = 10,
  parameter int unsigned pc_width  = PC_WIDTH,
  parameter int unsigned cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 if_valid,
  input  logic [pc_width-1:0]  if_pc,
  input  logic [1:0]           if_pred,
  input  logic                 if_btb_hit,
  input  logic [pc_width-1:0]  if_btb_target,
  output logic [pc_width-1:0]  if_next_pc,
  output logic [s_index-1:0]   rindex,
  input  logic                 ex_branch,
  input  logic                 ex_jump,
  input  logic                 ex_br_en,
  input  logic [pc_width-1:0]  ex_target,
  output logic                 load_bht,
  output logic [s_index-1:0]   windex,
  output logic [1:0]           idex_pred_state,
  output logic                 mispredict,
  output logic [pc_width-1:0]  redirect_pc,
  output logic [cnt_width-1:0] branch_cnt,
  output logic [cnt_width-1:0] mispred_cnt
);

  bp_meta_t if_entry;
  bp_meta_t ifid_q;
  bp_meta_t idex_q;

  logic pred_taken;
  logic kill;
  logic res;
  logic actual_taken;
  logic target_miss;

  // IF: form the next-PC guess and the metadata entry entering IF/ID.
  always_comb begin
    pred_taken             = state_says_taken(bht_state_e'(if_pred)) & if_btb_hit;
    if_next_pc             = pred_taken ? if_btb_target : (if_pc + pc_width'(4));
    rindex                 = if_pc[s_index+1:2];
    if_entry               = '0;
    if_entry.valid         = if_valid;
    if_entry.pc            = if_pc;
    if_entry.pred_state    = bht_state_e'(if_pred);
    if_entry.pred_taken    = pred_taken;
    if_entry.pred_target   = if_btb_target;
  end

  // A mispredict squashes the two younger-or-equal stages the same way an
  // external flush does.
  assign kill = flush | mispredict;

  bp_meta_reg u_ifid (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .kill  (kill),
    .d     (if_entry),
    .q     (ifid_q)
  );

  bp_meta_reg u_idex (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .kill  (kill),
    .d     (ifid_q),
    .q     (idex_q)
  );

  // EX: resolve the carried prediction against the actual outcome.
  always_comb begin
    res             = idex_q.valid & (ex_branch | ex_jump) & ~stall;
    actual_taken    = ex_br_en | ex_jump;
    target_miss     = actual_taken & idex_q.pred_taken & (ex_target != idex_q.pred_target);
    mispredict      = res & ((actual_taken != idex_q.pred_taken) | target_miss);
    load_bht        = res;
    windex          = idex_q.pc[s_index+1:2];
    idex_pred_state = idex_q.pred_state;
    redirect_pc     = '0;
    if (mispredict) begin
      redirect_pc = actual_taken ? ex_target : (idex_q.pc + pc_width'(4));
    end
  end

  // Statistics: count resolutions and mispredicts, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (res && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + cnt_width'(1);
      end
      if (mispredict && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + cnt_width'(1);
      end
    end
  end

endmodule

// File: tb/tb_bp_track_unit.sv
// Scoreboard bench for bp_track_unit: stimulus queues expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_bp_track_unit;

  localparam int unsigned SI = 10;
  localparam int unsigned PW = 32;
  localparam int unsigned CW = 2;   // narrow counters so saturation is reachable

  localparam int K_NEXT_PC = 0;
  localparam int K_RINDEX  = 1;
  localparam int K_LOAD    = 2;
  localparam int K_MISP    = 3;
  localparam int K_REDIR   = 4;
  localparam int K_WINDEX  = 5;
  localparam int K_STATE   = 6;
  localparam int K_BCNT    = 7;
  localparam int K_MCNT    = 8;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } chk_t;

  typedef struct {
    logic [SI-1:0] widx;
    logic [1:0]    st;
    logic          misp;
    logic [PW-1:0] redir;
  } res_t;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          flush;
  logic          if_valid;
  logic [PW-1:0] if_pc;
  logic [1:0]    if_pred;
  logic          if_btb_hit;
  logic [PW-1:0] if_btb_target;
  logic [PW-1:0] if_next_pc;
  logic [SI-1:0] rindex;
  logic          ex_branch;
  logic          ex_jump;
  logic          ex_br_en;
  logic [PW-1:0] ex_target;
  logic          load_bht;
  logic [SI-1:0] windex;
  logic [1:0]    idex_pred_state;
  logic          mispredict;
  logic [PW-1:0] redirect_pc;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mispred_cnt;

  chk_t chk_q[$];
  res_t res_q[$];
  int   total;
  int   bad;
  logic finish_req;

  bp_track_unit #(
    .s_index   (SI),
    .pc_width  (PW),
    .cnt_width (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_pred         (if_pred),
    .if_btb_hit      (if_btb_hit),
    .if_btb_target   (if_btb_target),
    .if_next_pc      (if_next_pc),
    .rindex          (rindex),
    .ex_branch       (ex_branch),
    .ex_jump         (ex_jump),
    .ex_br_en        (ex_br_en),
    .ex_target       (ex_target),
    .load_bht        (load_bht),
    .windex          (windex),
    .idex_pred_state (idex_pred_state),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .branch_cnt      (branch_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- monitor / scoreboard ----------------

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", nm, $time, act, exp);
    end
  endtask

  chk_t c;
  res_t r;

  // Compare queued direct expectations and resolutions away from the posedge.
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.kind)
        K_NEXT_PC: cmp("if_next_pc", if_next_pc, c.val);
        K_RINDEX:  cmp("rindex", 32'(rindex), c.val);
        K_LOAD:    cmp("load_bht", 32'(load_bht), c.val);
        K_MISP:    cmp("mispredict", 32'(mispredict), c.val);
        K_REDIR:   cmp("redirect_pc", redirect_pc, c.val);
        K_WINDEX:  cmp("windex", 32'(windex), c.val);
        K_STATE:   cmp("idex_pred_state", 32'(idex_pred_state), c.val);
        K_BCNT:    cmp("branch_cnt", 32'(branch_cnt), c.val);
        K_MCNT:    cmp("mispred_cnt", 32'(mispred_cnt), c.val);
        default:   cmp("bad_kind", 32'(c.kind), 32'hFFFF_FFFF);
      endcase
    end
    if (load_bht) begin
      if (res_q.size() == 0) begin
        cmp("unexpected_load_bht", 32'(load_bht), 32'd0);
      end else begin
        r = res_q.pop_front();
        cmp("res_windex", 32'(windex), 32'(r.widx));
        cmp("res_pred_state", 32'(idex_pred_state), 32'(r.st));
        cmp("res_mispredict", 32'(mispredict), 32'(r.misp));
        cmp("res_redirect_pc", redirect_pc, r.redir);
      end
    end else if (mispredict) begin
      cmp("mispredict_without_load", 32'(mispredict), 32'd0);
    end
    if (finish_req) begin
      cmp("pending_resolutions", 32'(res_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // ---------------- stimulus ----------------

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int kind, input logic [31:0] val);
    chk_t e;
    e.kind = kind;
    e.val  = val;
    chk_q.push_back(e);
  endtask

  task automatic expect_res(input logic [SI-1:0] widx, input logic [1:0] st,
                            input logic misp, input logic [PW-1:0] redir);
    res_t e;
    e.widx  = widx;
    e.st    = st;
    e.misp  = misp;
    e.redir = redir;
    res_q.push_back(e);
  endtask

  task automatic clear_ex();
    ex_branch = 1'b0;
    ex_jump   = 1'b0;
    ex_br_en  = 1'b0;
    ex_target = '0;
  endtask

  task automatic drive_if(input logic v, input logic [PW-1:0] pc, input logic [1:0] pred,
                          input logic hit, input logic [PW-1:0] tgt);
    if_valid      = v;
    if_pc         = pc;
    if_pred       = pred;
    if_btb_hit    = hit;
    if_btb_target = tgt;
  endtask

  // Issue one fetch, let it reach EX two edges later, resolve it, then check
  // the counters after the resolving edge. fill puts a fresh valid fetch in
  // IF during the resolve cycle so a mispredict has something to squash.
  task automatic run_br(input logic [PW-1:0] pc, input logic [1:0] pred, input logic hit,
                        input logic [PW-1:0] btgt, input logic [PW-1:0] nxt,
                        input logic [SI-1:0] idx, input logic br, input logic jmp,
                        input logic en, input logic [PW-1:0] etgt, input logic misp,
                        input logic [PW-1:0] redir, input logic fill,
                        input logic [1:0] exp_b, input logic [1:0] exp_m);
    drive_if(1'b1, pc, pred, hit, btgt);
    expect_now(K_NEXT_PC, nxt);
    expect_now(K_RINDEX, 32'(idx));
    step();
    if_valid = 1'b0;
    step();
    ex_branch = br;
    ex_jump   = jmp;
    ex_br_en  = en;
    ex_target = etgt;
    expect_res(idx, pred, misp, redir);
    if (fill) drive_if(1'b1, 32'h300, 2'b11, 1'b1, 32'h200);
    step();
    clear_ex();
    if_valid = 1'b0;
    expect_now(K_BCNT, 32'(exp_b));
    expect_now(K_MCNT, 32'(exp_m));
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    finish_req = 1'b0;
    rst_n      = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    drive_if(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    clear_ex();

    // Reset state: registered outputs zero, IF guess still combinational.
    #1;
    expect_now(K_NEXT_PC, 32'h4);
    expect_now(K_RINDEX, 32'h0);
    expect_now(K_LOAD, 32'h0);
    expect_now(K_MISP, 32'h0);
    expect_now(K_REDIR, 32'h0);
    expect_now(K_WINDEX, 32'h0);
    expect_now(K_STATE, 32'h0);
    expect_now(K_BCNT, 32'h0);
    expect_now(K_MCNT, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Correct taken prediction.
    run_br(32'h100, 2'b11, 1'b1, 32'h200, 32'h200, 10'h040,
           1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 2'd1, 2'd0);

    // Predicted not-taken, actually taken: redirect and squash both stages.
    run_br(32'h104, 2'b01, 1'b1, 32'h200, 32'h108, 10'h041,
           1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 2'd2, 2'd1);
    ex_branch = 1'b1;
    ex_br_en  = 1'b1;
    ex_target = 32'h999;
    expect_now(K_LOAD, 32'h0);
    expect_now(K_MISP, 32'h0);
    step();
    expect_now(K_LOAD, 32'h0);
    expect_now(K_MISP, 32'h0);
    step();
    clear_ex();

    // Taken as predicted, but jalr target differs from the BTB target.
    run_br(32'h108, 2'b10, 1'b1, 32'h200, 32'h200, 10'h042,
           1'b0, 1'b1, 1'b0, 32'h240, 1'b1, 32'h240, 1'b0, 2'd3, 2'd2);

    // Two more mispredicts: branch_cnt already saturated, mispred_cnt saturates.
    run_br(32'h120, 2'b00, 1'b0, 32'h0, 32'h124, 10'h048,
           1'b1, 1'b0, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 2'd3, 2'd3);
    run_br(32'h124, 2'b00, 1'b0, 32'h0, 32'h128, 10'h049,
           1'b1, 1'b0, 1'b1, 32'h404, 1'b1, 32'h404, 1'b0, 2'd3, 2'd3);

    // Reset with a would-be mispredicting branch sitting in ID/EX.
    drive_if(1'b1, 32'h118, 2'b11, 1'b1, 32'h200);
    expect_now(K_NEXT_PC, 32'h200);
    step();
    if_valid = 1'b0;
    step();
    rst_n     = 1'b0;
    ex_branch = 1'b1;
    ex_br_en  = 1'b0;
    ex_target = 32'h11C;
    expect_now(K_LOAD, 32'h0);
    expect_now(K_MISP, 32'h0);
    expect_now(K_REDIR, 32'h0);
    expect_now(K_WINDEX, 32'h0);
    expect_now(K_STATE, 32'h0);
    expect_now(K_BCNT, 32'h0);
    expect_now(K_MCNT, 32'h0);
    step();
    expect_now(K_LOAD, 32'h0);
    step();
    rst_n = 1'b1;
    expect_now(K_LOAD, 32'h0);
    expect_now(K_BCNT, 32'h0);
    expect_now(K_MCNT, 32'h0);
    step();
    expect_now(K_LOAD, 32'h0);
    expect_now(K_BCNT, 32'h0);
    step();
    clear_ex();

    // Stall for three cycles with a resolving branch in EX.
    drive_if(1'b1, 32'h10C, 2'b00, 1'b0, 32'h500);
    expect_now(K_NEXT_PC, 32'h110);
    expect_now(K_RINDEX, 32'h043);
    step();
    if_valid = 1'b0;
    step();
    stall     = 1'b1;
    ex_branch = 1'b1;
    ex_br_en  = 1'b0;
    ex_target = 32'h110;
    for (int i = 0; i < 3; i++) begin
      expect_now(K_LOAD, 32'h0);
      expect_now(K_MISP, 32'h0);
      expect_now(K_BCNT, 32'h0);
      step();
    end
    stall = 1'b0;
    expect_res(10'h043, 2'b00, 1'b0, 32'h0);
    step();
    expect_now(K_LOAD, 32'h0);
    expect_now(K_BCNT, 32'h1);
    expect_now(K_MCNT, 32'h0);
    step();
    clear_ex();

    // Flush and stall together: both stages must clear, not hold.
    drive_if(1'b1, 32'h110, 2'b11, 1'b1, 32'h200);
    expect_now(K_NEXT_PC, 32'h200);
    step();
    drive_if(1'b1, 32'h114, 2'b00, 1'b0, 32'h0);
    expect_now(K_NEXT_PC, 32'h118);
    step();
    if_valid = 1'b0;
    flush    = 1'b1;
    stall    = 1'b1;
    step();
    flush     = 1'b0;
    stall     = 1'b0;
    ex_branch = 1'b1;
    ex_br_en  = 1'b1;
    ex_target = 32'h999;
    expect_now(K_LOAD, 32'h0);
    step();
    expect_now(K_LOAD, 32'h0);
    step();
    clear_ex();
    expect_now(K_BCNT, 32'h1);
    expect_now(K_MCNT, 32'h0);
    step();

    finish_req = 1'b1;
  end

endmodule
